// File: rtl/sc_fifo.sv
// Single-clock synchronous FIFO with full-depth capacity, threshold flags,
// synchronous flush, sticky error flags and optional first-word-fall-through output.
module sc_fifo #(
    parameter type T          = logic [15:0],
    parameter int  L2DEPTH    = 3,
    parameter bit  FWFT       = 1'b0,
    parameter int  AFULL_LVL  = (2 ** L2DEPTH) - 2,
    parameter int  AEMPTY_LVL = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             err_clr,
    input  T                 wr_din,
    input  logic             wr_write,
    output logic             wr_full,
    output logic             wr_afull,
    input  logic             rd_read,
    output T                 rd_dout,
    output logic             rd_empty,
    output logic             rd_aempty,
    output logic [L2DEPTH:0] usedw,
    output logic             ovf,
    output logic             udf
);

    localparam int DEPTH = 2 ** L2DEPTH;
    localparam int CW    = L2DEPTH + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH_CNT  = cnt_t'(DEPTH);
    localparam cnt_t AFULL_CNT  = cnt_t'(AFULL_LVL);
    localparam cnt_t AEMPTY_CNT = cnt_t'(AEMPTY_LVL);

    if (L2DEPTH < 1) begin : g_depth_chk
        $fatal(1, "sc_fifo: L2DEPTH must be at least 1");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_afull_chk
        $fatal(1, "sc_fifo: AFULL_LVL out of range 1..DEPTH");
    end
    if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_aempty_chk
        $fatal(1, "sc_fifo: AEMPTY_LVL out of range 0..DEPTH-1");
    end

    T     mem_q [DEPTH];
    cnt_t wr_ptr_q, wr_ptr_d;
    cnt_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic full_q, full_d;
    logic afull_q, afull_d;
    logic empty_q, empty_d;
    logic aempty_q, aempty_d;
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;
    T     dout_q, dout_d;
    logic wr_acc, rd_acc;

    always_comb begin
        wr_acc   = wr_write && !full_q && !flush;
        rd_acc   = rd_read && !empty_q && !flush;
        wr_ptr_d = wr_ptr_q + cnt_t'(wr_acc);
        rd_ptr_d = rd_ptr_q + cnt_t'(rd_acc);
        count_d  = count_q + cnt_t'(wr_acc) - cnt_t'(rd_acc);
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        dout_d   = dout_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (err_clr) begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
            end
            // A rejection in the same cycle as err_clr must leave the flag set.
            if (wr_write && full_q)  ovf_d = 1'b1;
            if (rd_read  && empty_q) udf_d = 1'b1;
        end

        full_d   = (count_d == DEPTH_CNT);
        afull_d  = (count_d >= AFULL_CNT);
        empty_d  = (count_d == '0);
        aempty_d = (count_d <= AEMPTY_CNT);

        if (FWFT) begin
            // The new head is still in flight when it is the word being written now.
            if (count_d != '0) begin
                if (wr_acc && (rd_ptr_d[L2DEPTH-1:0] == wr_ptr_q[L2DEPTH-1:0]))
                    dout_d = wr_din;
                else
                    dout_d = mem_q[rd_ptr_d[L2DEPTH-1:0]];
            end
        end else if (rd_acc) begin
            dout_d = mem_q[rd_ptr_q[L2DEPTH-1:0]];
        end
    end

    // NOTE: storage has no reset; validity is tracked by the pointers, and a
    // reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[L2DEPTH-1:0]] <= wr_din;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dout_q   <= dout_d;
        end
    end

    assign wr_full   = full_q;
    assign wr_afull  = afull_q;
    assign rd_empty  = empty_q;
    assign rd_aempty = aempty_q;
    assign usedw     = count_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;
    assign rd_dout   = dout_q;

endmodule

// File: tb/tb_sc_fifo.sv
// Directed bench for sc_fifo: a registered-read instance and an FWFT instance,
// depth 8, default thresholds (afull at 6, aempty at 2).
module tb_sc_fifo;

    logic clk = 1'b0;
    logic rstn;

    logic        a_flush, a_err_clr, a_wr_write, a_rd_read;
    logic [15:0] a_wr_din, a_rd_dout;
    logic        a_wr_full, a_wr_afull, a_rd_empty, a_rd_aempty, a_ovf, a_udf;
    logic [3:0]  a_usedw;

    logic        b_flush, b_err_clr, b_wr_write, b_rd_read;
    logic [15:0] b_wr_din, b_rd_dout;
    logic        b_wr_full, b_wr_afull, b_rd_empty, b_rd_aempty, b_ovf, b_udf;
    logic [3:0]  b_usedw;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sc_fifo #(.L2DEPTH(3), .FWFT(1'b0)) u_dut (
        .clk(clk), .rstn(rstn), .flush(a_flush), .err_clr(a_err_clr),
        .wr_din(a_wr_din), .wr_write(a_wr_write), .wr_full(a_wr_full), .wr_afull(a_wr_afull),
        .rd_read(a_rd_read), .rd_dout(a_rd_dout), .rd_empty(a_rd_empty), .rd_aempty(a_rd_aempty),
        .usedw(a_usedw), .ovf(a_ovf), .udf(a_udf)
    );

    sc_fifo #(.L2DEPTH(3), .FWFT(1'b1)) u_dut_fwft (
        .clk(clk), .rstn(rstn), .flush(b_flush), .err_clr(b_err_clr),
        .wr_din(b_wr_din), .wr_write(b_wr_write), .wr_full(b_wr_full), .wr_afull(b_wr_afull),
        .rd_read(b_rd_read), .rd_dout(b_rd_dout), .rd_empty(b_rd_empty), .rd_aempty(b_rd_aempty),
        .usedw(b_usedw), .ovf(b_ovf), .udf(b_udf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_reset_state(input string tag);
        check({tag, " usedw"},  32'(a_usedw),     32'd0);
        check({tag, " full"},   32'(a_wr_full),   32'd0);
        check({tag, " afull"},  32'(a_wr_afull),  32'd0);
        check({tag, " empty"},  32'(a_rd_empty),  32'd1);
        check({tag, " aempty"}, 32'(a_rd_aempty), 32'd1);
        check({tag, " ovf"},    32'(a_ovf),       32'd0);
        check({tag, " udf"},    32'(a_udf),       32'd0);
        check({tag, " dout"},   32'(a_rd_dout),   32'd0);
    endtask

    task automatic write_a(input logic [15:0] d);
        a_wr_write = 1'b1;
        a_wr_din   = d;
        tick();
        a_wr_write = 1'b0;
    endtask

    task automatic read_a();
        a_rd_read = 1'b1;
        tick();
        a_rd_read = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        {a_flush, a_err_clr, a_wr_write, a_rd_read} = '0;
        {b_flush, b_err_clr, b_wr_write, b_rd_read} = '0;
        a_wr_din = '0;
        b_wr_din = '0;
        tick();
        tick();
        check_a_reset_state("reset");
        check("fwft reset empty", 32'(b_rd_empty), 32'd1);
        check("fwft reset dout",  32'(b_rd_dout),  32'd0);
        rstn = 1'b1;

        // Fill 1..8 with no reads.
        for (int i = 1; i <= 8; i++) begin
            write_a(16'(i));
            check($sformatf("fill%0d usedw", i),  32'(a_usedw),     32'(i));
            check($sformatf("fill%0d afull", i),  32'(a_wr_afull),  32'(i >= 6));
            check($sformatf("fill%0d full", i),   32'(a_wr_full),   32'(i == 8));
            check($sformatf("fill%0d aempty", i), 32'(a_rd_aempty), 32'(i <= 2));
            check($sformatf("fill%0d empty", i),  32'(a_rd_empty),  32'd0);
        end
        check("fill ovf", 32'(a_ovf), 32'd0);

        // Ninth write while full is rejected.
        write_a(16'h00FF);
        check("ovf set",        32'(a_ovf),   32'd1);
        check("ovf usedw",      32'(a_usedw), 32'd8);
        check("ovf dout held",  32'(a_rd_dout), 32'd0);

        // Drain in order; the rejected word must not appear.
        for (int i = 1; i <= 8; i++) begin
            read_a();
            check($sformatf("drain%0d dout", i),  32'(a_rd_dout), 32'(i));
            check($sformatf("drain%0d usedw", i), 32'(a_usedw),   32'(8 - i));
        end
        check("drain empty", 32'(a_rd_empty), 32'd1);
        check("drain full",  32'(a_wr_full),  32'd0);
        check("drain udf",   32'(a_udf),      32'd0);

        // Read from empty.
        read_a();
        check("udf set",       32'(a_udf),     32'd1);
        check("udf dout held", 32'(a_rd_dout), 32'd8);
        check("udf usedw",     32'(a_usedw),   32'd0);

        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;
        check("err_clr ovf", 32'(a_ovf), 32'd0);
        check("err_clr udf", 32'(a_udf), 32'd0);

        // Wrap-around with simultaneous traffic at constant occupancy 3.
        for (int i = 0; i < 3; i++) write_a(16'h0100 + 16'(i));
        for (int k = 0; k < 40; k++) begin
            a_wr_write = 1'b1;
            a_rd_read  = 1'b1;
            a_wr_din   = 16'h0103 + 16'(k);
            tick();
            check($sformatf("wrap%0d usedw", k), 32'(a_usedw),   32'd3);
            check($sformatf("wrap%0d dout", k),  32'(a_rd_dout), 32'h0100 + 32'(k));
        end
        a_wr_write = 1'b0;
        a_rd_read  = 1'b0;
        check("wrap ovf", 32'(a_ovf), 32'd0);
        check("wrap udf", 32'(a_udf), 32'd0);

        for (int i = 0; i < 3; i++) begin
            read_a();
            check($sformatf("wrap tail%0d", i), 32'(a_rd_dout), 32'h0128 + 32'(i));
        end

        // Full boundary: write+read together at usedw=8.
        for (int i = 0; i < 8; i++) write_a(16'h0200 + 16'(i));
        check("full pre usedw", 32'(a_usedw), 32'd8);
        a_wr_write = 1'b1;
        a_rd_read  = 1'b1;
        a_wr_din   = 16'h02FF;
        tick();
        a_wr_write = 1'b0;
        a_rd_read  = 1'b0;
        check("fullrw usedw", 32'(a_usedw),    32'd7);
        check("fullrw ovf",   32'(a_ovf),      32'd1);
        check("fullrw dout",  32'(a_rd_dout),  32'h0200);
        check("fullrw full",  32'(a_wr_full),  32'd0);
        check("fullrw afull", 32'(a_wr_afull), 32'd1);

        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            read_a();
            check($sformatf("fullrw drain%0d", i), 32'(a_rd_dout), 32'h0200 + 32'(i));
        end
        check("fullrw drained empty", 32'(a_rd_empty), 32'd1);

        // Empty boundary: write+read together at usedw=0.
        a_wr_write = 1'b1;
        a_rd_read  = 1'b1;
        a_wr_din   = 16'h0300;
        tick();
        a_wr_write = 1'b0;
        a_rd_read  = 1'b0;
        check("emptyrw usedw", 32'(a_usedw),    32'd1);
        check("emptyrw udf",   32'(a_udf),      32'd1);
        check("emptyrw ovf",   32'(a_ovf),      32'd0);
        check("emptyrw dout",  32'(a_rd_dout),  32'h0207);
        check("emptyrw empty", 32'(a_rd_empty), 32'd0);
        read_a();
        check("emptyrw read", 32'(a_rd_dout), 32'h0300);
        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;

        // Flush at usedw=5 with a concurrent write.
        for (int i = 0; i < 5; i++) write_a(16'h0400 + 16'(i));
        check("flush pre usedw", 32'(a_usedw), 32'd5);
        a_flush    = 1'b1;
        a_wr_write = 1'b1;
        a_wr_din   = 16'h04FF;
        tick();
        a_flush    = 1'b0;
        a_wr_write = 1'b0;
        check("flush usedw",  32'(a_usedw),     32'd0);
        check("flush empty",  32'(a_rd_empty),  32'd1);
        check("flush aempty", 32'(a_rd_aempty), 32'd1);
        check("flush afull",  32'(a_wr_afull),  32'd0);
        check("flush ovf",    32'(a_ovf),       32'd0);
        check("flush dout",   32'(a_rd_dout),   32'h0300);
        write_a(16'h0500);
        read_a();
        check("post flush dout",  32'(a_rd_dout),  32'h0500);
        check("post flush empty", 32'(a_rd_empty), 32'd1);

        // FWFT instance: bypass into empty, head follows reads.
        b_wr_write = 1'b1;
        b_wr_din   = 16'hBEEF;
        tick();
        b_wr_write = 1'b0;
        check("fwft bypass empty", 32'(b_rd_empty), 32'd0);
        check("fwft bypass dout",  32'(b_rd_dout),  32'hBEEF);
        check("fwft bypass usedw", 32'(b_usedw),    32'd1);
        b_wr_write = 1'b1;
        b_wr_din   = 16'h1234;
        tick();
        b_wr_write = 1'b0;
        check("fwft head stable", 32'(b_rd_dout), 32'hBEEF);
        b_rd_read = 1'b1;
        tick();
        b_rd_read = 1'b0;
        check("fwft next head", 32'(b_rd_dout), 32'h1234);
        check("fwft next usedw", 32'(b_usedw),  32'd1);
        b_rd_read  = 1'b1;
        b_wr_write = 1'b1;
        b_wr_din   = 16'h5678;
        tick();
        b_rd_read  = 1'b0;
        b_wr_write = 1'b0;
        check("fwft rw at one dout",  32'(b_rd_dout), 32'h5678);
        check("fwft rw at one usedw", 32'(b_usedw),   32'd1);
        b_rd_read = 1'b1;
        tick();
        check("fwft last empty", 32'(b_rd_empty), 32'd1);
        check("fwft last hold",  32'(b_rd_dout),  32'h5678);
        tick();
        b_rd_read = 1'b0;
        check("fwft udf",        32'(b_udf),     32'd1);
        check("fwft udf hold",   32'(b_rd_dout), 32'h5678);

        // Reset mid-operation at usedw=4.
        for (int i = 0; i < 4; i++) write_a(16'h0600 + 16'(i));
        check("rst pre usedw", 32'(a_usedw), 32'd4);
        rstn = 1'b0;
        tick();
        check_a_reset_state("midrst");
        check("midrst fwft udf", 32'(b_udf), 32'd0);
        rstn = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
